// File: rtl/cr16_pkg.sv
// Shared CR16 fetch-path widths, default instruction-store depth and the response record.
// Combinational only; no latency or backpressure of its own.
package cr16_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int MEM_DEPTH = 1024;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] address;
    logic              error;
  } rsp_t;

endpackage

// File: rtl/ifetch_responder_rsp_queue.sv
// Response FIFO: registered push/pop, zero-latency head, flush empties it and wins over a same-edge push.
// Backpressure: a push is dropped when full unless a pop frees a slot on the same edge.
module rsp_queue
  import cr16_pkg::*;
#(
  parameter  int P_DEPTH = 3,
  localparam int L_PTR_W = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1,
  localparam int L_CNT_W = $clog2(P_DEPTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_push,
  input  rsp_t               i_din,
  input  logic               i_pop,
  input  logic               i_flush,
  output logic [L_CNT_W-1:0] o_count,
  output logic               o_vld,
  output rsp_t               o_head
);

  rsp_t               r_mem [P_DEPTH];
  logic [L_PTR_W-1:0] r_rd;
  logic [L_PTR_W-1:0] r_wr;
  logic [L_CNT_W-1:0] r_cnt;

  logic w_full;
  logic w_pop;
  logic w_push;

  function automatic logic [L_PTR_W-1:0] f_inc(input logic [L_PTR_W-1:0] p);
    return (p == L_PTR_W'(P_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full = (r_cnt == L_CNT_W'(P_DEPTH));
  assign w_pop  = i_pop && (r_cnt != '0);
  assign w_push = i_push && (!w_full || w_pop) && !i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= f_inc(r_wr);
      if (w_pop)  r_rd <= f_inc(r_rd);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage is not reset; the head is forced to zero whenever the queue is empty.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

  assign o_count = r_cnt;
  assign o_vld   = (r_cnt != '0);
  assign o_head  = o_vld ? r_mem[r_rd] : '0;

endmodule

// File: rtl/ifetch_responder.sv
// Instruction-fetch responder: word memory read in stage 1, queued response 2 edges after acceptance.
// Backpressure: request ready drops when queued plus in-flight responses fill the queue; flush drops stale fetches.
module ifetch_responder
  import cr16_pkg::*;
#(
  parameter int P_ADDRESS_WIDTH = ADDR_W,
  parameter int P_DATA_WIDTH    = DATA_W,
  parameter int P_MEM_DEPTH     = MEM_DEPTH,
  parameter int P_QUEUE_DEPTH   = 3
) (
  input  logic                       I_CLK,
  input  logic                       I_NRESET,
  input  logic                       I_REQ_VALID,
  output logic                       O_REQ_READY,
  input  logic [P_ADDRESS_WIDTH-1:0] I_REQ_ADDRESS,
  output logic                       O_RSP_VALID,
  input  logic                       I_RSP_READY,
  output logic [P_DATA_WIDTH-1:0]    O_RSP_DATA,
  output logic [P_ADDRESS_WIDTH-1:0] O_RSP_ADDRESS,
  output logic                       O_RSP_ERROR,
  input  logic                       I_FLUSH,
  input  logic                       I_WRITE_ENABLE,
  input  logic [P_ADDRESS_WIDTH-1:0] I_WRITE_ADDRESS,
  input  logic [P_DATA_WIDTH-1:0]    I_WRITE_DATA
);

  localparam int L_IDX_W = $clog2(P_MEM_DEPTH);
  localparam int L_CNT_W = $clog2(P_QUEUE_DEPTH + 1);
  localparam logic [P_ADDRESS_WIDTH:0] L_DEPTH = (P_ADDRESS_WIDTH + 1)'(P_MEM_DEPTH);

  logic [P_DATA_WIDTH-1:0] r_mem [P_MEM_DEPTH];
  logic                    r_s1_vld;
  rsp_t                    r_s1;

  logic               w_req_acc;
  logic               w_rd_ok;
  logic               w_wr_ok;
  logic [L_IDX_W-1:0] w_rd_idx;
  logic [L_IDX_W-1:0] w_wr_idx;
  logic [L_CNT_W-1:0] w_count;
  rsp_t               w_head;

  assign w_req_acc = I_REQ_VALID && O_REQ_READY;
  // Range checks use the whole address; only the low bits index the array.
  assign w_rd_ok   = ({1'b0, I_REQ_ADDRESS} < L_DEPTH);
  assign w_wr_ok   = ({1'b0, I_WRITE_ADDRESS} < L_DEPTH);
  assign w_rd_idx  = I_REQ_ADDRESS[L_IDX_W-1:0];
  assign w_wr_idx  = I_WRITE_ADDRESS[L_IDX_W-1:0];

  always_ff @(posedge I_CLK) begin
    if (I_WRITE_ENABLE && w_wr_ok) r_mem[w_wr_idx] <= I_WRITE_DATA;
  end

  // A same-edge flush never kills this accept: it is the post-branch fetch.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      r_s1_vld <= 1'b0;
      r_s1     <= '0;
    end else begin
      r_s1_vld <= w_req_acc;
      if (w_req_acc) begin
        r_s1.data    <= w_rd_ok ? r_mem[w_rd_idx] : '0;
        r_s1.address <= I_REQ_ADDRESS;
        r_s1.error   <= !w_rd_ok;
      end
    end
  end

  rsp_queue #(.P_DEPTH(P_QUEUE_DEPTH)) u_rsp_queue (
    .i_clk   (I_CLK),
    .i_rst_n (I_NRESET),
    .i_push  (r_s1_vld),
    .i_din   (r_s1),
    .i_pop   (I_RSP_READY),
    .i_flush (I_FLUSH),
    .o_count (w_count),
    .o_vld   (O_RSP_VALID),
    .o_head  (w_head)
  );

  assign O_REQ_READY   = (32'(w_count) + 32'(r_s1_vld)) < 32'(P_QUEUE_DEPTH);
  assign O_RSP_DATA    = w_head.data;
  assign O_RSP_ADDRESS = w_head.address;
  assign O_RSP_ERROR   = w_head.error;

endmodule

// File: tb/tb_ifetch_responder.sv
// Directed bench for ifetch_responder: hand-computed expectations checked by immediate assertions.
module tb_ifetch_responder;

  logic        I_CLK = 1'b0;
  logic        I_NRESET = 1'b0;
  logic        I_REQ_VALID = 1'b0;
  logic        O_REQ_READY;
  logic [15:0] I_REQ_ADDRESS = '0;
  logic        O_RSP_VALID;
  logic        I_RSP_READY = 1'b0;
  logic [15:0] O_RSP_DATA;
  logic [15:0] O_RSP_ADDRESS;
  logic        O_RSP_ERROR;
  logic        I_FLUSH = 1'b0;
  logic        I_WRITE_ENABLE = 1'b0;
  logic [15:0] I_WRITE_ADDRESS = '0;
  logic [15:0] I_WRITE_DATA = '0;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] exp_mem [4];

  ifetch_responder dut (
    .I_CLK           (I_CLK),
    .I_NRESET        (I_NRESET),
    .I_REQ_VALID     (I_REQ_VALID),
    .O_REQ_READY     (O_REQ_READY),
    .I_REQ_ADDRESS   (I_REQ_ADDRESS),
    .O_RSP_VALID     (O_RSP_VALID),
    .I_RSP_READY     (I_RSP_READY),
    .O_RSP_DATA      (O_RSP_DATA),
    .O_RSP_ADDRESS   (O_RSP_ADDRESS),
    .O_RSP_ERROR     (O_RSP_ERROR),
    .I_FLUSH         (I_FLUSH),
    .I_WRITE_ENABLE  (I_WRITE_ENABLE),
    .I_WRITE_ADDRESS (I_WRITE_ADDRESS),
    .I_WRITE_DATA    (I_WRITE_DATA)
  );

  always #5 I_CLK = ~I_CLK;

  task automatic tick();
    @(posedge I_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_rsp(input string tag, input logic [15:0] d, input logic [15:0] a, input logic e);
    chk({tag, "_vld"}, 32'(O_RSP_VALID), 32'd1);
    chk({tag, "_dat"}, 32'(O_RSP_DATA), 32'(d));
    chk({tag, "_adr"}, 32'(O_RSP_ADDRESS), 32'(a));
    chk({tag, "_err"}, 32'(O_RSP_ERROR), 32'(e));
  endtask

  initial begin
    int acc;
    exp_mem[0] = 16'h1111;
    exp_mem[1] = 16'h2222;
    exp_mem[2] = 16'h3333;
    exp_mem[3] = 16'h4444;

    // Reset state
    #12;
    chk("rst_vld", 32'(O_RSP_VALID), 32'd0);
    chk("rst_dat", 32'(O_RSP_DATA), 32'd0);
    chk("rst_adr", 32'(O_RSP_ADDRESS), 32'd0);
    chk("rst_err", 32'(O_RSP_ERROR), 32'd0);
    @(negedge I_CLK);
    I_NRESET = 1'b1;
    tick();
    chk("rst_rdy", 32'(O_REQ_READY), 32'd1);

    // Load memory words 0..3
    for (int i = 0; i < 4; i++) begin
      I_WRITE_ENABLE  = 1'b1;
      I_WRITE_ADDRESS = 16'(i);
      I_WRITE_DATA    = exp_mem[i];
      tick();
    end
    I_WRITE_ENABLE = 1'b0;

    // Back-to-back fetches with the consumer always ready
    I_REQ_VALID = 1'b1;
    I_RSP_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      I_REQ_ADDRESS = 16'(i);
      chk("b2b_rdy", 32'(O_REQ_READY), 32'd1);
      tick();
      if (i == 0) chk("b2b_lat1", 32'(O_RSP_VALID), 32'd0);
      else chk_rsp("b2b", exp_mem[i-1], 16'(i - 1), 1'b0);
    end
    I_REQ_VALID = 1'b0;
    tick();
    chk_rsp("b2b_last", exp_mem[3], 16'd3, 1'b0);
    tick();
    chk("b2b_idle", 32'(O_RSP_VALID), 32'd0);

    // Consumer stalled: only the queue depth worth of requests gets in
    I_RSP_READY = 1'b0;
    I_REQ_VALID = 1'b1;
    acc = 0;
    I_REQ_ADDRESS = 16'd0;
    for (int i = 0; i < 6; i++) begin
      if (O_REQ_READY) acc++;
      tick();
      I_REQ_ADDRESS = 16'(acc);
    end
    I_REQ_VALID = 1'b0;
    chk("stall_acc", 32'(acc), 32'd3);
    chk("stall_rdy", 32'(O_REQ_READY), 32'd0);
    chk_rsp("stall_head", 16'h1111, 16'd0, 1'b0);
    tick();
    tick();
    chk_rsp("stall_hold", 16'h1111, 16'd0, 1'b0);
    I_RSP_READY = 1'b1;
    for (int j = 0; j < 3; j++) begin
      chk_rsp("drain", exp_mem[j], 16'(j), 1'b0);
      tick();
    end
    chk("drain_vld", 32'(O_RSP_VALID), 32'd0);
    chk("drain_rdy", 32'(O_REQ_READY), 32'd1);

    // Out-of-range read followed by a good one
    I_REQ_VALID   = 1'b1;
    I_REQ_ADDRESS = 16'd1024;
    tick();
    I_REQ_ADDRESS = 16'd1;
    tick();
    chk_rsp("oor", 16'h0000, 16'd1024, 1'b1);
    I_REQ_VALID = 1'b0;
    tick();
    chk_rsp("oor_next", 16'h2222, 16'd1, 1'b0);
    tick();
    chk("oor_idle", 32'(O_RSP_VALID), 32'd0);

    // Flush with two fetches in flight and a new fetch on the same edge
    I_RSP_READY   = 1'b0;
    I_REQ_VALID   = 1'b1;
    I_REQ_ADDRESS = 16'd0;
    tick();
    I_REQ_ADDRESS = 16'd1;
    tick();
    I_REQ_ADDRESS = 16'd3;
    I_FLUSH       = 1'b1;
    tick();
    I_FLUSH     = 1'b0;
    I_REQ_VALID = 1'b0;
    chk("flush_vld0", 32'(O_RSP_VALID), 32'd0);
    tick();
    chk_rsp("flush_new", 16'h4444, 16'd3, 1'b0);
    I_RSP_READY = 1'b1;
    tick();
    chk("flush_only1", 32'(O_RSP_VALID), 32'd0);

    // Read-first on a same-edge write, new data on the next read
    I_REQ_VALID     = 1'b1;
    I_REQ_ADDRESS   = 16'd2;
    I_WRITE_ENABLE  = 1'b1;
    I_WRITE_ADDRESS = 16'd2;
    I_WRITE_DATA    = 16'hBEEF;
    tick();
    I_WRITE_ENABLE = 1'b0;
    tick();
    chk_rsp("rfirst_old", 16'h3333, 16'd2, 1'b0);
    I_REQ_VALID = 1'b0;
    tick();
    chk_rsp("rfirst_new", 16'hBEEF, 16'd2, 1'b0);
    tick();

    // Asynchronous reset with two queued entries
    I_RSP_READY   = 1'b0;
    I_REQ_VALID   = 1'b1;
    I_REQ_ADDRESS = 16'd0;
    tick();
    I_REQ_ADDRESS = 16'd1;
    tick();
    I_REQ_VALID = 1'b0;
    tick();
    chk("arst_pre_vld", 32'(O_RSP_VALID), 32'd1);
    #2;
    I_NRESET = 1'b0;
    #1;
    chk("arst_vld", 32'(O_RSP_VALID), 32'd0);
    chk("arst_dat", 32'(O_RSP_DATA), 32'd0);
    @(negedge I_CLK);
    I_NRESET = 1'b1;
    tick();
    chk("arst_rdy", 32'(O_REQ_READY), 32'd1);
    chk("arst_idle", 32'(O_RSP_VALID), 32'd0);
    I_RSP_READY   = 1'b1;
    I_REQ_VALID   = 1'b1;
    I_REQ_ADDRESS = 16'd3;
    tick();
    I_REQ_VALID = 1'b0;
    chk("arst_lat1", 32'(O_RSP_VALID), 32'd0);
    tick();
    chk_rsp("arst_rsp", 16'h4444, 16'd3, 1'b0);
    tick();
    chk("arst_end", 32'(O_RSP_VALID), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ifetch_responder.md
Name: ifetch_responder

Overview:
Responder side of the instruction-fetch interface. The program counter issues fetch addresses, and this block services them from an internal word-addressed instruction memory. It returns each instruction word, tagged with its address, through a valid/ready response channel. It sits between the CR16 program counter/FSM and the instruction store, and provides a flush so that a taken branch or jump discards stale fetches.

Parameters:
P_ADDRESS_WIDTH, 16, width of request/response address
P_DATA_WIDTH, 16, width of instruction word
P_MEM_DEPTH, 1024, number of memory words; valid addresses are 0 .. P_MEM_DEPTH-1
P_QUEUE_DEPTH, 3, response queue entries; must be >= 2

Ports:
I_CLK  input  1  clock, all state updates on rising edge
I_NRESET  input  1  asynchronous active-low reset
I_REQ_VALID  input  1  fetch request present
O_REQ_READY  output  1  block can accept a request this cycle
I_REQ_ADDRESS  input  P_ADDRESS_WIDTH  fetch address
O_RSP_VALID  output  1  response present at queue head
I_RSP_READY  input  1  consumer takes the head response this cycle
O_RSP_DATA  output  P_DATA_WIDTH  instruction word
O_RSP_ADDRESS  output  P_ADDRESS_WIDTH  address the word was fetched from
O_RSP_ERROR  output  1  address was out of range; O_RSP_DATA is 0
I_FLUSH  input  1  discard all in-flight and queued responses
I_WRITE_ENABLE  input  1  memory load/store write strobe
I_WRITE_ADDRESS  input  P_ADDRESS_WIDTH  write address
I_WRITE_DATA  input  P_DATA_WIDTH  write data

Behaviour:
- Reset (async, I_NRESET low): pipeline valid=0, queue empty, O_RSP_VALID=0, O_RSP_DATA=0, O_RSP_ADDRESS=0, O_RSP_ERROR=0. Memory contents are not reset.
- A request is accepted at a rising edge when I_REQ_VALID and O_REQ_READY are both high.
- Stage 1, edge k: the accepted address is registered together with the synchronous memory read and the range check (address >= P_MEM_DEPTH sets error).
- Stage 2, edge k+1: the stage-1 result is pushed into the response queue.
- The earliest O_RSP_VALID is in the cycle after edge k+1, so latency is 2 edges.
- O_RSP_* always shows the queue head. It is held stable while O_RSP_VALID=1 and I_RSP_READY=0.
- O_REQ_READY = (queue_count + stage1_valid) < P_QUEUE_DEPTH. It is driven from registers only, with no combinational path from I_RSP_READY.
- With P_QUEUE_DEPTH=3 and I_RSP_READY held high, throughput is 1 response per cycle.
- Ordering: responses leave strictly in request order. Queue push and pop in the same edge are both performed; count is unchanged.
- Out-of-range read: O_RSP_DATA=0 and O_RSP_ERROR=1. The address is still echoed.
- Out-of-range write: ignored.
- Memory write at edge e is visible to reads accepted at edge e+1 or later.
- Read and write to the same address at the same edge: the read returns the old data (read-first).
- Flush at edge f: stage1_valid and the queue are cleared, and O_RSP_VALID=0 after f.
  - A request accepted at the same edge f is kept and responds normally, because it is the post-branch fetch.
  - A pop at the same edge f is still treated as consumed.
- Reset mid-operation: all in-flight and queued responses are lost. After release, the first accepted request behaves as if from idle.
- Address arithmetic: the memory index is the low ceil(log2(P_MEM_DEPTH)) address bits. The range check uses the full address width.

Decomposition:
- Shared package cr16_pkg holds the widths (address 16, data 16) and default memory depth as localparams, plus the response struct type (data, address, error).
- One natural sub-module: rsp_queue.
  - Parameterised synchronous FIFO carrying the response struct, with push, pop, flush, count, and head outputs.
  - The block itself instantiates the memory array, stage 1 and the ready logic.

Test Plan:
- Load mem[0..3]=0x1111,0x2222,0x3333,0x4444, release reset, request addresses 0,1,2,3 back-to-back with I_RSP_READY=1 -> O_RSP_VALID rises 2 edges after the first acceptance; data 0x1111..0x4444 on 4 consecutive cycles, addresses match, O_REQ_READY stays 1.
- I_RSP_READY=0 while requesting continuously -> exactly 3 requests accepted, then O_REQ_READY=0. The head holds addr 0 data 0x1111 stable. After I_RSP_READY=1, all 3 drain in order and ready returns.
- Request address P_MEM_DEPTH (1024) -> response data 0, O_RSP_ERROR=1, address 1024. A following request to addr 1 returns 0x2222 with error 0.
- Two requests in flight, assert I_FLUSH together with a new request to addr 3 -> only one response appears (0x4444, addr 3).
- Write 0xBEEF to addr 2 at the same edge a read of addr 2 is accepted -> the read returns 0x3333; the next read of addr 2 returns 0xBEEF.
- Pulse I_NRESET low asynchronously, mid-clock, with the queue holding 2 entries -> O_RSP_VALID=0 immediately. After release, O_REQ_READY=1 and the next request returns correct data with latency 2.
